// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that shares one SPI transaction engine among N_REQ requesters.
// Drives the go/end handshake, returns read data, enforces an idle gap and a watchdog.
module spi_xfer_arbiter #(
    parameter int N_REQ      = 3,
    parameter int P2S_W      = 16,
    parameter int S2P_W      = 8,
    parameter int GAP_CYCLES = 4,
    parameter int TO_W       = 12
) (
    input  logic                     iSPI_CLK,
    input  logic                     iRSTN,
    input  logic [N_REQ-1:0]         iREQ,
    input  logic [N_REQ*P2S_W-1:0]   iREQ_DATA,
    output logic [N_REQ-1:0]         oGNT,
    output logic [N_REQ-1:0]         oDONE,
    output logic [S2P_W-1:0]         oRD_DATA,
    output logic                     oTIMEOUT,
    output logic                     oBUSY,
    output logic                     oSPI_GO,
    output logic [P2S_W-1:0]         oP2S_DATA,
    input  logic                     iSPI_END,
    input  logic [S2P_W-1:0]         iS2P_DATA
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    // Abort on the edge where the watchdog would reach 2^TO_W-1.
    localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RELEASE,
        GAP
    } state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [IW-1:0]   owner;
    logic [TO_W-1:0] wdog;
    logic [GW-1:0]   gap_cnt;

    logic [IW-1:0]   pick;
    logic            found;
    int              k;

    // First requester after the last winner, wrapping modulo N_REQ.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        k     = 0;
        for (int j = 1; j <= N_REQ; j++) begin
            k = int'(last) + j;
            if (k >= N_REQ) k = k - N_REQ;
            if (!found && iREQ[k]) begin
                found = 1'b1;
                pick  = IW'(k);
            end
        end
    end

    always_ff @(posedge iSPI_CLK) begin
        if (!iRSTN) begin
            state     <= IDLE;
            last      <= IW'(N_REQ - 1);
            owner     <= '0;
            wdog      <= '0;
            gap_cnt   <= '0;
            oGNT      <= '0;
            oDONE     <= '0;
            oRD_DATA  <= '0;
            oTIMEOUT  <= 1'b0;
            oBUSY     <= 1'b0;
            oSPI_GO   <= 1'b0;
            oP2S_DATA <= '0;
        end else begin
            oDONE    <= '0;
            oTIMEOUT <= 1'b0;
            case (state)
                IDLE: begin
                    if (found && !iSPI_END) begin
                        owner     <= pick;
                        oGNT      <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                        oP2S_DATA <= iREQ_DATA[int'(pick)*P2S_W +: P2S_W];
                        oSPI_GO   <= 1'b1;
                        oBUSY     <= 1'b1;
                        wdog      <= '0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (iSPI_END || wdog == WD_LAST) begin
                        oSPI_GO  <= 1'b0;
                        oRD_DATA <= iSPI_END ? iS2P_DATA : '0;
                        oTIMEOUT <= !iSPI_END;
                        oDONE    <= oGNT;
                        last     <= owner;
                        state    <= RELEASE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!iSPI_END) begin
                        oGNT <= '0;
                        if (GAP_CYCLES == 0) begin
                            oBUSY <= 1'b0;
                            state <= IDLE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        oBUSY <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
Shares the single SPI transaction engine (spi_controller go/end handshake, 16-bit parallel-to-serial word, 8-bit serial-to-parallel result) among N_REQ independent requesters, e.g. init writer, axis poller and host register access. Performs round-robin arbitration and drives the go/end handshake on the winner's behalf. Returns read data with a one-cycle done strobe, enforces a minimum idle gap between transactions, and aborts hung transfers with a watchdog. Sits between requester logic and spi_controller, in the iSPI_CLK domain.

Parameters:
N_REQ, 3, number of requesters (2..8)
P2S_W, 16, transaction word width sent to the controller
S2P_W, 8, read-back width from the controller
GAP_CYCLES, 4, minimum idle cycles between oSPI_GO falling and the next rise (0 allowed)
TO_W, 12, watchdog counter width; timeout after 2^TO_W-1 cycles in XFER

Ports:
iSPI_CLK  in  1  clock. Single clock domain.
iRSTN  in  1  reset, synchronous, active-low
iREQ  in  N_REQ  per-requester request level
iREQ_DATA  in  N_REQ*P2S_W  flattened words; requester i occupies [i*P2S_W +: P2S_W]
oGNT  out  N_REQ  one-hot owner of the current transaction
oDONE  out  N_REQ  one-cycle completion strobe to the owner
oRD_DATA  out  S2P_W  read-back data, valid when any oDONE bit is high
oTIMEOUT  out  1  one-cycle strobe, coincident with oDONE, on watchdog abort
oBUSY  out  1  high in every state except IDLE
oSPI_GO  out  1  to controller iSPI_GO
oP2S_DATA  out  P2S_W  to controller iP2S_DATA
iSPI_END  in  1  from controller oSPI_END
iS2P_DATA  in  S2P_W  from controller oS2P_DATA

Behaviour:
- Reset values: all outputs 0; state IDLE; last-granted pointer = N_REQ-1, so requester 0 has first priority; timers cleared. Reset is sampled only on a clock edge.
- Reset asserted mid-transfer: oSPI_GO is 0 after that edge and no oDONE is issued.
- All outputs are registered.
- States: IDLE, XFER, RELEASE, GAP.
- IDLE, at an edge where iREQ != 0 and iSPI_END == 0:
  - pick the first set bit scanning from last+1 upward, wrapping modulo N_REQ;
  - register oGNT one-hot and oP2S_DATA = the winner's word;
  - set oSPI_GO=1, clear the watchdog, go to XFER.
- IDLE latency: request sampled at edge k gives oGNT and oSPI_GO high after edge k.
- IDLE with iREQ == 0, or with iSPI_END still high: stay.
- XFER, iSPI_END==1:
  - oSPI_GO<=0, oRD_DATA<=iS2P_DATA, oDONE<=oGNT for one cycle;
  - last<=winner index; go to RELEASE.
- XFER, watchdog reaches 2^TO_W-1 without iSPI_END:
  - same actions as iSPI_END==1, plus oTIMEOUT=1 and oRD_DATA<=0.
- XFER otherwise: watchdog increments and oP2S_DATA is held constant.
- RELEASE: wait for iSPI_END==0, then clear oGNT. Go to GAP, or to IDLE if GAP_CYCLES==0.
- GAP: count GAP_CYCLES cycles, then go to IDLE. Requests arriving during GAP wait; none are lost.
- Requester protocol:
  - hold iREQ and iREQ_DATA stable until its oDONE;
  - iREQ_DATA is captured at grant only, so later changes are ignored;
  - dropping iREQ after grant does not cancel the transaction; oDONE still pulses;
  - a requester may re-raise iREQ on the cycle after oDONE. It is then lowest priority if others are pending.
- Fairness: with all N_REQ requesting continuously, grants rotate i, i+1, ..., and each requester is served once per N_REQ transactions.
- Simultaneous events in IDLE: only one grant is issued per arbitration; the others wait.
- An iSPI_END high while in IDLE or GAP (spurious) is ignored.
- No combinational path from iREQ to oSPI_GO.

Test Plan:
- Reset then single request: iREQ=3'b010, word 16'h8B00; iS2P_DATA=8'h5A, iSPI_END high 20 cycles after go.
  -> oGNT=010 and oSPI_GO=1 one edge after request; oP2S_DATA=8B00.
  -> oDONE=010 for one cycle with oRD_DATA=5A; next go no earlier than 4 cycles after oSPI_GO falls.
- All three requesting continuously for 6 transactions -> grant order 0,1,2,0,1,2; each oDONE exactly once per round.
- Requester 1 drops iREQ mid-XFER, and requester 0 changes iREQ_DATA mid-XFER.
  -> the transaction completes with the originally captured word; oDONE[1] still pulses.
- Controller never asserts iSPI_END (TO_W=4) -> after 15 XFER cycles:
  - oSPI_GO=0, oTIMEOUT=1 and oDONE for the owner, oRD_DATA=0;
  - the next request is served normally.
- iRSTN low for one edge mid-XFER -> oSPI_GO, oGNT, oBUSY are 0 after that edge, and no oDONE is issued.
- After reset, the first grant goes to requester 0.
- iSPI_END held high for 3 cycles after go falls -> state stays RELEASE; no new go until iSPI_END is low and the gap has elapsed.
